md_rot_buf: RTL and testbench

- Parametrised N-bank rotating mode buffer for the intra mode pipeline.
- The mode-decision stage writes the current CTU's modes into one bank.
- NUM_RD downstream consumers (rec, ec, ...) each read the banks of earlier CTUs at a fixed stage lag.
- Bank roles rotate on every system start pulse. Adds over the previous fixed 4-bank buffer: registered read-valid, per-bank fill tracking with stale indication, and safe rotation/read overlap.

---
 rtl/md_rot_buf.sv | 177 +++++++++++++++++
 tb/tb_md_rot_buf.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_rot_buf.sv
// Rotating N-bank intra-mode buffer: one write bank plus NUM_RD lagged read banks, roles advance on rot_i.
// Optional macro MD_ROT_BUF_CLR_EN adds a zero-fill sweep of each newly assigned write bank.
module md_rot_buf #(
    parameter int NUM_BANK = 4,
    parameter int NUM_RD   = 2,
    parameter int DEPTH    = 64,
    parameter int DW       = 6,
    parameter int WR_AW    = 8,
    parameter int WR_SHIFT = 2,
    parameter int AW       = 6,
    localparam int BW      = $clog2(NUM_BANK)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rot_i,
    input  logic                 wr_ena_i,
    input  logic [WR_AW-1:0]     wr_adr_i,
    input  logic [DW-1:0]        wr_dat_i,
    output logic                 wr_rdy_o,
    input  logic [NUM_RD-1:0]    rd_ena_i,
    input  logic [NUM_RD*AW-1:0] rd_adr_i,
    output logic [NUM_RD*DW-1:0] rd_dat_o,
    output logic [NUM_RD-1:0]    rd_vld_o,
    output logic [NUM_RD-1:0]    rd_stale_o,
    output logic [BW-1:0]        wr_bank_o,
    output logic                 busy_o
);

    logic [BW-1:0]       p_q, p_d;
    logic [NUM_BANK-1:0] filled_q, filled_d;
    logic [BW-1:0]       rd_bank [NUM_RD];
    logic [AW-1:0]       wr_a;
    logic                wr_fire;
    logic                clr_act;
    logic [AW-1:0]       clr_adr;
    logic [DW-1:0]       bank_rdat [NUM_BANK];

    logic [NUM_RD-1:0]   rd_vld_q;
    logic [NUM_RD-1:0]   rd_fill_q;
    logic [BW-1:0]       rd_bank_q [NUM_RD];
    logic [DW-1:0]       rd_hold_q [NUM_RD];

    assign wr_a      = AW'(wr_adr_i >> WR_SHIFT);
    assign wr_fire   = wr_ena_i & wr_rdy_o;
    assign wr_bank_o = p_q;

`ifdef MD_ROT_BUF_CLR_EN
    logic          busy_q, busy_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;

    // A rotation (even mid-sweep) restarts the sweep on the new write bank.
    always_comb begin
        busy_d    = busy_q;
        clr_cnt_d = clr_cnt_q;
        if (rot_i) begin
            busy_d    = 1'b1;
            clr_cnt_d = '0;
        end else if (busy_q) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == AW'(DEPTH - 1))
                busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            clr_cnt_q <= '0;
        end else begin
            busy_q    <= busy_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign busy_o   = busy_q;
    assign wr_rdy_o = ~busy_q;
    assign clr_act  = busy_q;
    assign clr_adr  = clr_cnt_q;
`else
    assign busy_o   = 1'b0;
    assign wr_rdy_o = 1'b1;
    assign clr_act  = 1'b0;
    assign clr_adr  = '0;
`endif

    // Pointer and fill tracking; a same-cycle write still marks the old bank.
    always_comb begin
        p_d      = p_q;
        filled_d = filled_q;
        if (wr_fire)
            filled_d[p_q] = 1'b1;
        if (rot_i) begin
            p_d           = p_q + 1'b1;
            filled_d[p_d] = 1'b0;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_RD; k++)
            rd_bank[k] = p_q - BW'(k + 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q      <= '0;
            filled_q <= '0;
        end else begin
            p_q      <= p_d;
            filled_q <= filled_d;
        end
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        logic [DW-1:0] ram [DEPTH];
        logic [DW-1:0] rdat_q;
        logic          is_wr;
        logic          rd_hit;
        logic [AW-1:0] rd_a;

        // Each bank has a single owner per cycle, so one address mux suffices.
        always_comb begin
            is_wr  = (p_q == BW'(b));
            rd_hit = 1'b0;
            rd_a   = '0;
            for (int k = 0; k < NUM_RD; k++) begin
                if (rd_ena_i[k] && rd_bank[k] == BW'(b)) begin
                    rd_hit = 1'b1;
                    rd_a   = rd_adr_i[k*AW +: AW];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (is_wr) begin
                if (clr_act)
                    ram[clr_adr] <= '0;
                else if (wr_fire)
                    ram[wr_a] <= wr_dat_i;
            end else if (rd_hit) begin
                rdat_q <= ram[rd_a];
            end
        end

        assign bank_rdat[b] = rdat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q  <= '0;
            rd_fill_q <= '0;
            for (int k = 0; k < NUM_RD; k++) begin
                rd_bank_q[k] <= '0;
                rd_hold_q[k] <= '0;
            end
        end else begin
            rd_vld_q <= rd_ena_i;
            for (int k = 0; k < NUM_RD; k++) begin
                if (rd_ena_i[k]) begin
                    rd_bank_q[k] <= rd_bank[k];
                    rd_fill_q[k] <= filled_q[rd_bank[k]];
                end
                if (rd_vld_q[k])
                    rd_hold_q[k] <= bank_rdat[rd_bank_q[k]];
            end
        end
    end

    always_comb begin
        rd_dat_o = '0;
        for (int k = 0; k < NUM_RD; k++)
            rd_dat_o[k*DW +: DW] = rd_vld_q[k] ? bank_rdat[rd_bank_q[k]] : rd_hold_q[k];
    end

    assign rd_vld_o   = rd_vld_q;
    assign rd_stale_o = rd_vld_q & ~rd_fill_q;

endmodule

// File: tb/tb_md_rot_buf.sv
// Directed bench for md_rot_buf: role rotation, read latency/stale, rotation overlap, reset abort,
// and (with MD_ROT_BUF_CLR_EN) the clear sweep.
module tb_md_rot_buf;

    localparam int DW = 6;
    localparam int AW = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         rot_i;
    logic         wr_ena_i;
    logic [7:0]   wr_adr_i;
    logic [DW-1:0] wr_dat_i;
    logic         wr_rdy_o;
    logic [1:0]   rd_ena_i;
    logic [2*AW-1:0] rd_adr_i;
    logic [2*DW-1:0] rd_dat_o;
    logic [1:0]   rd_vld_o;
    logic [1:0]   rd_stale_o;
    logic [1:0]   wr_bank_o;
    logic         busy_o;

    int n_vec = 0;
    int n_err = 0;

    md_rot_buf dut (
        .clk        (clk),
        .rst        (rst),
        .rot_i      (rot_i),
        .wr_ena_i   (wr_ena_i),
        .wr_adr_i   (wr_adr_i),
        .wr_dat_i   (wr_dat_i),
        .wr_rdy_o   (wr_rdy_o),
        .rd_ena_i   (rd_ena_i),
        .rd_adr_i   (rd_adr_i),
        .rd_dat_o   (rd_dat_o),
        .rd_vld_o   (rd_vld_o),
        .rd_stale_o (rd_stale_o),
        .wr_bank_o  (wr_bank_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rot_i    = 1'b0;
        wr_ena_i = 1'b0;
        rd_ena_i = 2'b00;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_rot();
        idle();
        rot_i = 1'b1;
        tick();
        rot_i = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] adr, input logic [DW-1:0] dat);
        idle();
        wr_ena_i = 1'b1;
        wr_adr_i = adr;
        wr_dat_i = dat;
        tick();
        wr_ena_i = 1'b0;
    endtask

    task automatic test_reset();
        wr_adr_i = '0;
        wr_dat_i = '0;
        rd_adr_i = '0;
        do_reset();
        n_vec++;
        if ({rd_vld_o, rd_stale_o, rd_dat_o, busy_o, wr_rdy_o, wr_bank_o} !== {2'b00, 2'b00, 12'h000, 1'b0, 1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL reset: vld=%b stale=%b dat=%h busy=%b rdy=%b bank=%0d, need 00 00 000 0 1 0",
                     rd_vld_o, rd_stale_o, rd_dat_o, busy_o, wr_rdy_o, wr_bank_o);
        end
    endtask

    task automatic test_write_read();
        do_reset();
        for (int i = 0; i < 4; i++)
            do_write(8'(4 * i), DW'(i + 1));
        do_rot();
        n_vec++;
        if (wr_bank_o !== 2'd1) begin
            n_err++;
            $display("FAIL wr_read_bank: got %0d need 1", wr_bank_o);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            rd_ena_i = 2'b01;
            rd_adr_i = {6'd0, 6'(i)};
            tick();
            n_vec++;
            if ({rd_vld_o, rd_stale_o[0], rd_dat_o[5:0]} !== {2'b01, 1'b0, 6'(i + 1)}) begin
                n_err++;
                $display("FAIL rd_p0[%0d]: vld=%b stale0=%b dat=%h need 01 0 %h",
                         i, rd_vld_o, rd_stale_o[0], rd_dat_o[5:0], 6'(i + 1));
            end
        end
        idle();
        tick();
        n_vec++;
        if ({rd_vld_o, rd_dat_o[5:0]} !== {2'b00, 6'd4}) begin
            n_err++;
            $display("FAIL rd_hold: vld=%b dat=%h need 00 04", rd_vld_o, rd_dat_o[5:0]);
        end
    endtask

    // Continues from test_write_read (p=1, bank 0 holds 1..4).
    task automatic test_lag();
        do_rot();
        idle();
        rd_ena_i = 2'b11;
        rd_adr_i = '0;
        tick();
        n_vec++;
        if ({wr_bank_o, rd_vld_o, rd_stale_o, rd_dat_o[11:6]} !== {2'd2, 2'b11, 2'b01, 6'd1}) begin
            n_err++;
            $display("FAIL lag: bank=%0d vld=%b stale=%b dat1=%h need 2 11 01 01",
                     wr_bank_o, rd_vld_o, rd_stale_o, rd_dat_o[11:6]);
        end
    endtask

    task automatic test_rotate_seq();
        logic [1:0] exp_bank [5];
        exp_bank = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        do_write(8'd0, 6'd7);
        for (int i = 0; i < 5; i++) begin
            do_rot();
            n_vec++;
            if (wr_bank_o !== exp_bank[i]) begin
                n_err++;
                $display("FAIL rot_seq[%0d]: got %0d need %0d", i, wr_bank_o, exp_bank[i]);
            end
            if (i == 0) begin
                idle();
                rd_ena_i = 2'b01;
                rd_adr_i = '0;
                tick();
                n_vec++;
                if ({rd_vld_o[0], rd_stale_o[0], rd_dat_o[5:0]} !== {1'b1, 1'b0, 6'd7}) begin
                    n_err++;
                    $display("FAIL rot_fresh: vld0=%b stale0=%b dat=%h need 1 0 07",
                             rd_vld_o[0], rd_stale_o[0], rd_dat_o[5:0]);
                end
            end
        end
        // Bank 0 was reassigned to the write role at the 4th rotation, so its flag is cleared.
        idle();
        rd_ena_i = 2'b01;
        rd_adr_i = '0;
        tick();
        n_vec++;
        if ({rd_vld_o[0], rd_stale_o[0]} !== 2'b11) begin
            n_err++;
            $display("FAIL rot_stale: vld0=%b stale0=%b need 1 1", rd_vld_o[0], rd_stale_o[0]);
        end
    endtask

    task automatic test_rot_overlap();
        do_reset();
        do_write(8'd0, 6'd5);
        do_rot();
        idle();
        repeat (70) tick();
        rot_i    = 1'b1;
        wr_ena_i = 1'b1;
        wr_adr_i = 8'd0;
        wr_dat_i = 6'h2A;
        rd_ena_i = 2'b01;
        rd_adr_i = '0;
        tick();
        idle();
        n_vec++;
        if ({wr_bank_o, rd_vld_o[0], rd_stale_o[0], rd_dat_o[5:0]} !== {2'd2, 1'b1, 1'b0, 6'd5}) begin
            n_err++;
            $display("FAIL overlap_rd: bank=%0d vld0=%b stale0=%b dat=%h need 2 1 0 05",
                     wr_bank_o, rd_vld_o[0], rd_stale_o[0], rd_dat_o[5:0]);
        end
        rd_ena_i = 2'b01;
        tick();
        n_vec++;
        if ({rd_vld_o[0], rd_stale_o[0], rd_dat_o[5:0]} !== {1'b1, 1'b0, 6'h2A}) begin
            n_err++;
            $display("FAIL overlap_wr: vld0=%b stale0=%b dat=%h need 1 0 2a",
                     rd_vld_o[0], rd_stale_o[0], rd_dat_o[5:0]);
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        do_rot();
        idle();
        rd_ena_i = 2'b11;
        rd_adr_i = '0;
        tick();
        n_vec++;
        if (rd_vld_o !== 2'b11) begin
            n_err++;
            $display("FAIL inflight_pre: vld=%b need 11", rd_vld_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        n_vec++;
        if ({rd_vld_o, wr_bank_o, busy_o, wr_rdy_o, rd_dat_o} !== {2'b00, 2'd0, 1'b0, 1'b1, 12'h000}) begin
            n_err++;
            $display("FAIL inflight_rst: vld=%b bank=%0d busy=%b rdy=%b dat=%h need 00 0 0 1 000",
                     rd_vld_o, wr_bank_o, busy_o, wr_rdy_o, rd_dat_o);
        end
    endtask

`ifdef MD_ROT_BUF_CLR_EN
    task automatic test_clear_sweep();
        do_reset();
        do_rot();
        wr_ena_i = 1'b1;
        wr_adr_i = 8'd0;
        wr_dat_i = 6'h3F;
        for (int i = 0; i < 64; i++) begin
            n_vec++;
            if ({busy_o, wr_rdy_o} !== 2'b10) begin
                n_err++;
                $display("FAIL sweep_busy[%0d]: busy=%b rdy=%b need 1 0", i, busy_o, wr_rdy_o);
            end
            tick();
        end
        idle();
        n_vec++;
        if ({busy_o, wr_rdy_o} !== 2'b01) begin
            n_err++;
            $display("FAIL sweep_done: busy=%b rdy=%b need 0 1", busy_o, wr_rdy_o);
        end
        do_rot();
        for (int i = 0; i < 64; i++) begin
            idle();
            rd_ena_i = 2'b01;
            rd_adr_i = {6'd0, 6'(i)};
            tick();
            n_vec++;
            if ({rd_vld_o[0], rd_dat_o[5:0]} !== {1'b1, 6'd0}) begin
                n_err++;
                $display("FAIL sweep_zero[%0d]: vld0=%b dat=%h need 1 00", i, rd_vld_o[0], rd_dat_o[5:0]);
            end
        end
        idle();
    endtask
`else
    task automatic test_no_sweep();
        do_reset();
        do_rot();
        n_vec++;
        if ({busy_o, wr_rdy_o} !== 2'b01) begin
            n_err++;
            $display("FAIL no_sweep: busy=%b rdy=%b need 0 1", busy_o, wr_rdy_o);
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_lag();
        test_rotate_seq();
        test_rot_overlap();
        test_reset_inflight();
`ifdef MD_ROT_BUF_CLR_EN
        test_clear_sweep();
`else
        test_no_sweep();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
